seq_magnitude_comparator: RTL
=============================

// Module: seq_magnitude_comparator
//
// PURPOSE
//   Parametrised, multi-cycle magnitude comparator: successor to the fixed 4-bit combinational comparator.
//   Compares two WIDTH-bit operands MSB-first, CHUNK bits per clock; supports signed/unsigned mode per transaction.
//   Optional early exit on the first differing chunk.
//   Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
//
// PARAMETERS
//   WIDTH      16  operand width in bits; WIDTH % CHUNK == 0 (elaboration error otherwise)
//   CHUNK       4  bits compared per cycle; 1 <= CHUNK <= WIDTH
//   EARLY_EXIT  1  1: finish at first differing chunk; 0: always examine all NCHUNK = WIDTH/CHUNK chunks
//
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand transaction offered
//   in_ready   out  1      block can accept (high only in IDLE)
//   a          in   WIDTH  operand A, sampled on input handshake
//   b          in   WIDTH  operand B, sampled on input handshake
//   is_signed  in   1      1: two's-complement compare; 0: unsigned; sampled on input handshake
//   out_valid  out  1      result available
//   out_ready  in   1      consumer accepts result
//   a_gt_b     out  1      A > B   (one-hot with eq/lt while out_valid; all 0 otherwise)
//   a_eq_b     out  1      A == B
//   a_lt_b     out  1      A < B
//   busy       out  1      high in CMP or DONE
//
// BEHAVIOUR
//   Reset (async, any state):
//   - state->IDLE; out_valid, a_gt_b, a_eq_b, a_lt_b, busy = 0; in_ready = 1.
//   - In-flight transaction discarded silently.
//   FSM IDLE -> CMP -> DONE -> IDLE:
//   - IDLE: in_ready=1. On in_valid&&in_ready: capture a, b, is_signed; idx=NCHUNK-1; go to CMP.
//   - CMP: in_ready=0. Each clock compare chunk idx of the operand registers.
//     - Top chunk in signed mode: MSB of both operands inverted before unsigned compare (offset binary).
//     - Chunk differs, EARLY_EXIT=1: latch gt/lt, go to DONE.
//     - Chunk differs, EARLY_EXIT=0: latch only the first difference; later chunks cannot overwrite it.
//     - Chunk equal and idx!=0: idx--, stay in CMP.
//     - idx==0: go to DONE. Result is eq if no difference was latched.
//   - DONE: out_valid=1. Result outputs registered and stable until out_ready.
//     On out_valid&&out_ready: clear result outputs, go to IDLE.
//   Latency:
//   - out_valid rises k edges after the accepting edge.
//   - k = index of the deciding chunk counted from MSB (1..NCHUNK) if EARLY_EXIT=1; else k = NCHUNK.
//   - CHUNK==WIDTH gives k=1.
//   Throughput:
//   - No overlap: in_ready stays 0 in DONE, even when out_ready is high in the same cycle.
//   - Next accept is no earlier than the cycle after the output handshake.
//   Backpressure: out_ready low holds DONE indefinitely; outputs must not change.
//   Operands are never re-sampled after capture; changes on a/b/is_signed during CMP/DONE are ignored.
//   Never X on outputs after reset; exactly one result bit set whenever out_valid=1.
//
// STRUCTURE
//   Package cmp_pkg:
//   - typedef enum logic [1:0] {ST_IDLE, ST_CMP, ST_DONE} cmp_state_t
//   - typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_result_t
//   Sub-module cmp_chunk: combinational, parameter CHUNK.
//   - Inputs: a_c, b_c, invert_msb. Outputs: gt, eq, lt.
//   - One instance, driven by an idx-selected slice.
//   Top: FSM, operand/index registers, result latch, handshake logic.
//
// TESTING  (WIDTH=16, CHUNK=4 unless stated)
//   1. unsigned A=0x1234, B=0x1234 -> a_eq_b=1 only; out_valid 4 edges after accept.
//   2. unsigned A=0x8000, B=0x7FFF -> a_gt_b=1; k=1 (early exit on top chunk).
//   3. signed A=0x8000 (-32768), B=0x7FFF -> a_lt_b=1, k=1.
//      Signed A=0xFFFF, B=0xFFFE -> a_gt_b=1, k=4.
//   4. unsigned A=0x1235, B=0x1234, out_ready low 3 cycles -> a_gt_b held stable, in_ready=0, busy=1;
//      handshake then clears the result. Same stimulus with EARLY_EXIT=0 on A=0x9000, B=0x1000 -> gt, k=4.
//   5. accept A=0xFFFF, B=0xFFFF; assert rst 2 cycles later ->
//      same cycle out_valid=0, busy=0, in_ready=1, all result bits 0;
//      then A=0x0001, B=0x0002 -> a_lt_b=1, k=4.
//   6. in_valid held high with out_ready=1 for 3 transactions -> each accepted the cycle after the prior
//      output handshake; a/b toggled during CMP has no effect on results.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator.
// FSM state encoding and the three-way compare result.
package cmp_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_CMP, ST_DONE} cmp_state_t;
   typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_result_t;

   function automatic cmp_result_t to_result(logic gt, logic lt);
      if (gt)
         return CMP_GT;
      else if (lt)
         return CMP_LT;
      else
         return CMP_EQ;
   endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
// invert_msb turns a two's-complement top slice into offset binary.
module cmp_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a_c,
   input  logic [CHUNK-1:0] b_c,
   input  logic             invert_msb,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   logic [CHUNK-1:0] mask;
   logic [CHUNK-1:0] a_x;
   logic [CHUNK-1:0] b_x;

   always_comb begin
      mask = '0;
      mask[CHUNK-1] = invert_msb;
   end

   assign a_x = a_c ^ mask;
   assign b_x = b_c ^ mask;
   assign gt  = a_x > b_x;
   assign eq  = a_x == b_x;
   assign lt  = a_x < b_x;

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per clock,
// with valid/ready handshakes on the operand and result sides.
module seq_magnitude_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int CHUNK      = 4,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             a_gt_b,
   output logic             a_eq_b,
   output logic             a_lt_b,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("WIDTH must be a positive multiple of CHUNK");
   end

   cmp_state_t state, state_n;

   logic [WIDTH-1:0] a_q, b_q;
   logic             sgn_q;
   logic [IW-1:0]    idx;
   logic             hit_q;
   cmp_result_t      res_q;
   cmp_result_t      first;
   logic             finish;

   logic [WIDTH-1:0] a_sh, b_sh;
   logic [CHUNK-1:0] a_c, b_c;
   logic             c_gt, c_eq, c_lt;

   assign a_sh = a_q >> (CHUNK * int'(idx));
   assign b_sh = b_q >> (CHUNK * int'(idx));
   assign a_c  = a_sh[CHUNK-1:0];
   assign b_c  = b_sh[CHUNK-1:0];

   cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_c        (a_c),
      .b_c        (b_c),
      .invert_msb (sgn_q && (idx == LAST)),
      .gt         (c_gt),
      .eq         (c_eq),
      .lt         (c_lt)
   );

   // The first differing chunk decides; later chunks never override it.
   assign first  = hit_q ? res_q : to_result(c_gt, c_lt);
   assign finish = (EARLY_EXIT && !c_eq) || (idx == '0);

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_n = ST_CMP;
         end
         ST_CMP: begin
            busy = 1'b1;
            if (finish)
               state_n = ST_DONE;
         end
         ST_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready)
               state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         a_q    <= '0;
         b_q    <= '0;
         sgn_q  <= 1'b0;
         idx    <= '0;
         hit_q  <= 1'b0;
         res_q  <= CMP_EQ;
         a_gt_b <= 1'b0;
         a_eq_b <= 1'b0;
         a_lt_b <= 1'b0;
      end else begin
         state <= state_n;
         unique case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  sgn_q <= is_signed;
                  idx   <= LAST;
                  hit_q <= 1'b0;
                  res_q <= CMP_EQ;
               end
            end
            ST_CMP: begin
               res_q <= first;
               hit_q <= hit_q | ~c_eq;
               if (finish) begin
                  a_gt_b <= (first == CMP_GT);
                  a_eq_b <= (first == CMP_EQ);
                  a_lt_b <= (first == CMP_LT);
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  a_gt_b <= 1'b0;
                  a_eq_b <= 1'b0;
                  a_lt_b <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
